// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave
// Byte-oriented I2C target with a 7-bit address. SCL and SDA are oversampled
// on clk through 2-flop synchronizers; all protocol decisions are made from
// the synchronized levels and their edge strobes.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   i2c_scl   bus clock from the master
//   i2c_sda   open-drain data (driven 0 or Z only)
//   tx_data   byte returned to the master on a read
//   tx_req    1-cycle pulse: tx_data captured, next byte may be presented
//   rx_data   last byte written by the master
//   rx_valid  1-cycle pulse: rx_data updated
//   addr_hit  1-cycle pulse: address matched and ACKed
//   busy      high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module i2c_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h55
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
    } state_t;

    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       byte_done_reg;   // 8 bits sampled, act on the next SCL fall
    logic       rw_reg;
    logic       master_ack_reg;  // SDA level sampled on the 9th read clock
    logic       sda_oe_reg;      // 1 = pull SDA low
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       tx_req_reg;
    logic       addr_hit_reg;

    // Index 0 = SCL, index 1 = SDA
    logic [1:0] pin_raw;
    logic [1:0] pin_lvl;
    logic [1:0] pin_rise;
    logic [1:0] pin_fall;

    assign pin_raw = {i2c_sda, i2c_scl};

    // Two synchronizing flops plus one delayed copy for edge detection.
    // Preset to 1 so a reset looks like an idle (pulled-up) bus.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [2:0] sh_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) sh_reg <= 3'b111;
                else        sh_reg <= {sh_reg[1:0], pin_raw[gi]};
            end
            assign pin_lvl[gi]  = sh_reg[1];
            assign pin_rise[gi] = sh_reg[1] & ~sh_reg[2];
            assign pin_fall[gi] = ~sh_reg[1] & sh_reg[2];
        end
    endgenerate

    logic scl_rise, scl_fall, sda_lvl, start_det, stop_det;
    assign scl_rise  = pin_rise[0];
    assign scl_fall  = pin_fall[0];
    assign sda_lvl   = pin_lvl[1];
    assign start_det = pin_fall[1] & pin_lvl[0];
    assign stop_det  = pin_rise[1] & pin_lvl[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            byte_done_reg  <= 1'b0;
            rw_reg         <= 1'b0;
            master_ack_reg <= 1'b1;
            sda_oe_reg     <= 1'b0;
            rx_data_reg    <= 8'h00;
            rx_valid_reg   <= 1'b0;
            tx_req_reg     <= 1'b0;
            addr_hit_reg   <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            tx_req_reg   <= 1'b0;
            addr_hit_reg <= 1'b0;
            if (stop_det) begin
                // STOP outranks any SCL edge seen in the same cycle
                state_reg     <= IDLE;
                sda_oe_reg    <= 1'b0;
                bit_cnt_reg   <= 3'd0;
                byte_done_reg <= 1'b0;
            end else if (start_det) begin
                // Also covers repeated START; a partial byte is discarded
                state_reg     <= ADDR;
                sda_oe_reg    <= 1'b0;
                bit_cnt_reg   <= 3'd0;
                byte_done_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: ;
                    ADDR, WRITE: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_lvl};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;  // wraps 7->0
                            if (bit_cnt_reg == 3'd7) byte_done_reg <= 1'b1;
                        end else if (scl_fall && byte_done_reg) begin
                            byte_done_reg <= 1'b0;
                            if (state_reg == ADDR) begin
                                if (shift_reg[7:1] == SLV_ADDR) begin
                                    state_reg    <= ADDR_ACK;
                                    sda_oe_reg   <= 1'b1;
                                    addr_hit_reg <= 1'b1;
                                    rw_reg       <= shift_reg[0];
                                end else begin
                                    state_reg <= IDLE;
                                end
                            end else begin
                                rx_data_reg  <= shift_reg;
                                rx_valid_reg <= 1'b1;
                                state_reg    <= WRITE_ACK;
                                sda_oe_reg   <= 1'b1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_reg <= 3'd0;
                            if (rw_reg) begin
                                // Release the ACK and present bit 7 together
                                state_reg  <= READ;
                                shift_reg  <= tx_data;
                                tx_req_reg <= 1'b1;
                                sda_oe_reg <= ~tx_data[7];
                            end else begin
                                state_reg  <= WRITE;
                                sda_oe_reg <= 1'b0;
                            end
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            state_reg   <= WRITE;
                            sda_oe_reg  <= 1'b0;
                            bit_cnt_reg <= 3'd0;
                        end
                    end
                    READ: begin
                        // Bits advance on SCL fall; bit_cnt counts bits already sent
                        if (scl_fall) begin
                            if (bit_cnt_reg == 3'd7) begin
                                state_reg   <= READ_ACK;
                                sda_oe_reg  <= 1'b0;
                                bit_cnt_reg <= 3'd0;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                sda_oe_reg  <= ~shift_reg[6];
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            master_ack_reg <= sda_lvl;
                        end else if (scl_fall) begin
                            if (!master_ack_reg) begin
                                state_reg  <= READ;
                                shift_reg  <= tx_data;
                                tx_req_reg <= 1'b1;
                                sda_oe_reg <= ~tx_data[7];
                            end else begin
                                state_reg  <= IDLE;
                                sda_oe_reg <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_reg  <= IDLE;
                        sda_oe_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Gating with reset lets SDA float the instant reset is asserted
    assign i2c_sda  = (sda_oe_reg && reset) ? 1'b0 : 1'bz;
    assign tx_req   = tx_req_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign addr_hit = addr_hit_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLV_ADDR, 7'h55, 7-bit bus address this block answers to.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 i2c_scl  input  1  bus clock from the I2C master.
REQ-005 i2c_sda  inout  1  open-drain data; driven 1'b0 or 1'bz only, never 1'b1.
REQ-006 tx_data  input  8  byte returned to the master on a read.
REQ-007 tx_req  output  1  one-cycle pulse: tx_data captured, next byte may be presented.
REQ-008 rx_data  output  8  last byte written by the master.
REQ-009 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-010 addr_hit  output  1  one-cycle pulse: address matched and ACKed.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 i2c_scl and i2c_sda SHALL each pass a 2-flop synchronizer; an extra delayed copy gives scl_rise, scl_fall, sda_rise, sda_fall (2-3 clk latency from pin).
REQ-013 START (sda_fall while synced SCL high) SHALL, from any state including mid-byte (repeated start), enter ADDR, clear bit counter, release SDA.
REQ-014 STOP (sda_rise while synced SCL high) SHALL, from any state, enter IDLE and release SDA; STOP wins over any same-cycle SCL edge.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
REQ-016 Data bits SHALL be sampled on scl_rise, MSB first; SDA drive changes only on scl_fall.
REQ-017 A 3-bit counter SHALL count bits 0..7 per byte and wrap to 0 when entering an ACK state.
REQ-018 ADDR: after the 8th scl_rise, on the next scl_fall, if byte[7:1]==SLV_ADDR, enter ADDR_ACK, drive SDA low, pulse addr_hit, latch rw=byte[0]; otherwise enter IDLE and ignore the bus until the next START.
REQ-019 ADDR_ACK: hold SDA low through the 9th clock; on its scl_fall release SDA and go to WRITE if rw=0, or to READ if rw=1.
REQ-020 On entering READ, tx_data SHALL be loaded into the shift register, tx_req pulses once, and bit 7 is driven on the same cycle.
REQ-021 WRITE: after the 8th scl_rise, on the next scl_fall, rx_data gets the byte, rx_valid pulses once, and the block enters WRITE_ACK driving SDA low; the 9th scl_fall releases SDA and returns to WRITE.
REQ-022 READ: drive SDA low for a 0 bit and Z for a 1 bit; after the 8th bit's scl_fall, release SDA and enter READ_ACK.
REQ-023 READ_ACK: sample SDA on the 9th scl_rise. If low (ACK), the 9th scl_fall reloads tx_data, pulses tx_req, and returns to READ. If high (NACK), SDA stays released and the block enters IDLE.
REQ-024 A write byte cut short by START or STOP SHALL NOT update rx_data or pulse rx_valid.
REQ-025 Pulse outputs SHALL never be high for more than one consecutive cycle.

Reset
REQ-026 While reset=0: state=IDLE, counter=0, SDA released (Z), rx_data=8'h00, rx_valid=0, tx_req=0, addr_hit=0, busy=0, synchronizers preset to 1 (idle bus).
REQ-027 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); after release the block waits in IDLE for a fresh START.

Verification
REQ-028 Bench SHALL model a pull-up on i2c_sda and run SCL at least 8 clk periods per half-cycle.
REQ-029 Write: START, 0xAA (addr 0x55, W), data 0xAA, STOP -> SDA low at both 9th clocks; addr_hit pulses once; rx_data=8'hAA; rx_valid pulses once; busy=0 after STOP.
REQ-030 Mismatch: START, 0xA8 (addr 0x54) -> SDA never driven low; addr_hit, rx_valid and tx_req stay 0; state IDLE until the next START.
REQ-031 Read: tx_data=8'h01, START, 0xAB, master ACKs byte 1 with tx_data=8'h80, NACKs byte 2 -> bus bits 00000001 then 10000000; tx_req pulses twice; SDA released after the NACK.
REQ-032 Repeated start: START, 0xAA, 4 data bits, START, 0xAB -> no rx_valid; read phase begins with an ACK on the address.
REQ-033 Reset mid-read while driving a 0 bit -> SDA goes Z within the same cycle; outputs match REQ-026; a following full write transaction completes correctly.
